// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: fetch-side and decode-side handshake bundle for the
// instruction prefetch queue. The master modport is the queue's own view.
interface if_prefetch_queue_if #(
  parameter int ADDR_W = 32
);
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_ready;
  logic              im_rvalid;
  logic [31:0]       im_rdata;
  logic              id_valid;
  logic [31:0]       id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc4;
  logic              id_pred_taken;
  logic              id_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output im_req, im_addr, id_valid, id_inst, id_pc, id_pc4, id_pred_taken,
    input  im_ready, im_rvalid, im_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  im_req, im_addr, id_valid, id_inst, id_pc, id_pc4, id_pred_taken,
    output im_ready, im_rvalid, im_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end. Keeps several IM requests in
// flight, buffers returned words in a DEPTH-entry in-order queue and presents
// one instruction per cycle to decode. A redirect squashes queued and
// in-flight instructions. Requests are only issued when a queue slot is
// reserved for their response, so a returning word can never overflow.
// Optional feature: define IFQ_STATIC_PREDICT_EN to predecode JAL responses
// and redirect fetch internally to the jump target.
module if_prefetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1000_0000
) (
  input logic                 clk,
  input logic                 rst,
  if_prefetch_queue_if.master bus
);
  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [31:0]       q_inst [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DEPTH-1:0]  q_pred;
  logic [CW-1:0]     rd_ptr, wr_ptr, count, outstanding, discard;
  logic [ADDR_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]     tag_rd, tag_wr;

  logic              credit_ok, resp_keep, pred_hit, issue, push, pop;
  logic [ADDR_W-1:0] resp_pc, next_fetch_pc;
  logic [PW-1:0]     head_idx, wr_idx;

  assign head_idx = rd_ptr[PW-1:0];
  assign wr_idx   = wr_ptr[PW-1:0];
  assign resp_pc  = tag_mem[tag_rd];

`ifdef IFQ_STATIC_PREDICT_EN
  // Sign-extended J-type immediate of a JAL instruction.
  function automatic logic [ADDR_W-1:0] jal_offset(input logic [31:0] inst);
    logic [20:0] imm;
    imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return {{(ADDR_W - 21){imm[20]}}, imm};
  endfunction

  // Predecode kept responses: a JAL not overridden by an external redirect steers fetch.
  always_comb begin
    pred_hit      = resp_keep && !bus.redirect && (bus.im_rdata[6:0] == 7'b1101111);
    next_fetch_pc = resp_pc + jal_offset(bus.im_rdata);
  end
`else
  // No predecode: fetch advances sequentially until an external redirect.
  always_comb begin
    pred_hit      = 1'b0;
    next_fetch_pc = fetch_pc + ADDR_W'(4);
  end
`endif

  // Issue credit and per-cycle queue events; any redirect blocks issue this cycle.
  always_comb begin
    credit_ok  = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
    resp_keep  = bus.im_rvalid && (discard == CW'(0));
    bus.im_req = !rst && !bus.redirect && !pred_hit && credit_ok;
    issue      = bus.im_req && bus.im_ready;
    push       = resp_keep && !bus.redirect;
    pop        = bus.id_valid && bus.id_ready && !bus.redirect;
  end

  assign bus.im_addr       = fetch_pc;
  assign bus.id_valid      = (count != CW'(0));
  assign bus.id_inst       = bus.id_valid ? q_inst[head_idx] : NOP;
  assign bus.id_pc         = q_pc[head_idx];
  assign bus.id_pc4        = q_pc[head_idx] + ADDR_W'(4);
  assign bus.id_pred_taken = bus.id_valid && q_pred[head_idx];

  // Fetch PC, request tag FIFO, queue storage, pointers and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= CW'(0);
      wr_ptr      <= CW'(0);
      count       <= CW'(0);
      outstanding <= CW'(0);
      discard     <= CW'(0);
      tag_rd      <= PW'(0);
      tag_wr      <= PW'(0);
      q_pred      <= DEPTH'(0);
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i]  <= 32'h0;
        q_pc[i]    <= ADDR_W'(0);
        tag_mem[i] <= ADDR_W'(0);
      end
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(bus.im_rvalid);
      // Every response, kept or discarded, retires the oldest issued tag.
      if (issue) begin
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= tag_wr + PW'(1);
      end
      if (bus.im_rvalid) begin
        tag_rd <= tag_rd + PW'(1);
      end
      if (push) begin
        q_inst[wr_idx] <= bus.im_rdata;
        q_pc[wr_idx]   <= resp_pc;
        q_pred[wr_idx] <= pred_hit;
      end
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
        rd_ptr   <= wr_ptr;
        count    <= CW'(0);
        discard  <= outstanding - CW'(bus.im_rvalid);
      end else begin
        if (pred_hit) begin
          fetch_pc <= next_fetch_pc;
          discard  <= outstanding - CW'(1);
        end else begin
          if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
          end
          if (bus.im_rvalid && (discard != CW'(0))) begin
            discard <= discard - CW'(1);
          end
        end
        if (push) begin
          wr_ptr <= wr_ptr + CW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + CW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  if_prefetch_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .outstanding (outstanding),
    .discard     (discard),
    .push        (push),
    .pop         (pop)
  );
endmodule

// if_prefetch_queue_chk: occupancy invariants of the prefetch queue.
module if_prefetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] discard,
  input logic          push,
  input logic          pop
);
  // Credits never exceed DEPTH and discards are a subset of in-flight requests.
  always @(posedge clk) begin
    if (!rst) begin
      assert (outstanding <= CW'(DEPTH));
      assert (discard <= outstanding);
      assert (({1'b0, count} + {1'b0, outstanding}) <= (CW + 1)'(DEPTH));
      assert (!(push && !pop && (count == CW'(DEPTH))));
    end
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed and randomized checks of the prefetch queue
// against a queue-level model of the IM and the decode stream.
module tb_if_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h1000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  if_prefetch_queue_if #(.ADDR_W(32)) bus ();

  if_prefetch_queue #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          pops     = 0;
  int          xfers    = 0;
  pend_t       pend[$];
  logic [31:0] fifo[$];
  logic [31:0] fetch    = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.im_ready    = 1'b0;
    bus.im_rvalid   = 1'b0;
    bus.im_rdata    = 32'h0;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_im_req", bus.im_req, 1'b0);
    chk("rst_im_addr", bus.im_addr, RESET_PC);
    chk("rst_id_valid", bus.id_valid, 1'b0);
    chk("rst_id_inst", bus.id_inst, NOP);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_pc4", bus.id_pc4, 32'h4);
    chk("rst_id_pred", bus.id_pred_taken, 1'b0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    fifo.delete();
    fetch = RESET_PC;
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit rdy_id, input bit rdy_im, input bit redir, input logic [31:0] rpc);
    bit          resp;
    bit          exp_req;
    bit          xfer;
    logic [31:0] head;
    pend_t       e;
    resp = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.id_ready    = rdy_id;
    bus.im_ready    = rdy_im;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.im_rvalid   = resp;
    bus.im_rdata    = resp ? mem_word(pend[0].addr) : $urandom();
    #1;
    exp_req = !redir && ((pend.size() + fifo.size()) < DEPTH);
    chk("im_req", bus.im_req, exp_req);
    chk("im_addr", bus.im_addr, fetch);
    chk("id_valid", bus.id_valid, fifo.size() > 0);
    chk("id_pred", bus.id_pred_taken, 1'b0);
    if (fifo.size() > 0) begin
      head = fifo[0];
      chk("id_pc", bus.id_pc, head);
      chk("id_inst", bus.id_inst, mem_word(head));
      chk("id_pc4", bus.id_pc4, head + 32'd4);
    end else begin
      chk("id_inst_nop", bus.id_inst, NOP);
    end
    if ((fifo.size() > 0) && rdy_id && !redir) begin
      void'(fifo.pop_front());
      pops++;
    end
    xfer = exp_req && rdy_im;
    if (resp) begin
      e = pend.pop_front();
      if (!e.stale && !redir) fifo.push_back(e.addr);
    end
    if (redir) begin
      fifo.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      fetch = rpc;
    end else if (xfer) begin
      xfers++;
      e.addr  = fetch;
      e.due   = cyc + $urandom_range(lat_max, lat_min);
      e.stale = 1'b0;
      pend.push_back(e);
      fetch = fetch + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if ((pend.size() == 0) && (fifo.size() == 0)) break;
      step(1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk("drain_empty", bus.id_valid, 1'b0);
  endtask

  initial begin
    int          p0;
    int          x0;
    bit          found;
    logic [31:0] r;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // Streaming: 1-cycle IM, always ready.
    lat_min = 1; lat_max = 1;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    p0 = pops;
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("throughput", pops - p0, 10);

    // Decode stalled: exactly DEPTH requests, then in-order release.
    drain();
    x0 = xfers;
    repeat (10) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_issued", xfers - x0, DEPTH);
    p0 = pops;
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_release", pops - p0, DEPTH);

    // 3-cycle IM, redirect with three requests in flight.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 10; k++) begin
      if (pend.size() == 3) break;
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    step(1'b1, 1'b1, 1'b1, 32'h1000_0100);
    for (int k = 0; k < 20; k++) begin
      if (bus.id_valid) break;
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("redir_valid", bus.id_valid, 1'b1);
    chk("redir_first_pc", bus.id_pc, 32'h1000_0100);

    // Redirect colliding with a response and a pop.
    drain();
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ((pend.size() > 0) && (pend[0].due <= cyc) && (fifo.size() > 0)) begin
        step(1'b1, 1'b1, 1'b1, 32'h2000_0000);
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    chk("collision_found", found, 1'b1);

    // IM not ready: address holds, nothing reaches decode.
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("hold_addr", bus.im_addr, 32'h2000_0000);
    chk("hold_no_valid", bus.id_valid, 1'b0);

    // Randomized traffic with a reset in the middle.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      r = $urandom();
      r[1:0] = 2'b00;
      step($urandom_range(99) < 70, $urandom_range(99) < 75, $urandom_range(99) < 4, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
